// File: rtl/lsb_mem_ctrl.sv
// Purpose: serves one LSB load/store (1, 2 or 4 bytes) as byte-serial accesses on the 8-bit RAM/IO bus.
// Latency: load of N bytes completes (lsb_valid) in cycle N+2, store of N bytes in cycle N+1.
// Backpressure: rdy_in low freezes everything; IO stores wait while io_buffer_full is high.
module lsb_mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        lsb_enable,
  input  logic [2:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic        lsb_wr_tag,
  output logic        lsb_valid,
  output logic [31:0] lsb_rdata,
  output logic        busy,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_len;      // bytes in this request: 1, 2 or 4
  logic [2:0]  r_issue;    // bytes already put on the bus
  logic [2:0]  r_cap;      // read bytes already captured
  logic        r_rd_vld;   // mem_a this cycle carries a read address
  logic        r_din_vld;  // mem_din this cycle carries a requested byte

  logic [2:0]  w_req_len;
  logic        w_req_stall;
  logic        w_io_stall;
  logic [31:0] w_issue_addr;
  logic [7:0]  w_issue_byte;

  // Decode request size and the per-byte address/data for the next issue
  always_comb begin
    case (lsb_size)
      3'd1:    w_req_len = 3'd1;
      3'd2:    w_req_len = 3'd2;
      default: w_req_len = 3'd4;
    endcase
    w_req_stall  = (lsb_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    w_io_stall   = (r_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    w_issue_addr = r_addr + {29'd0, r_issue};
    w_issue_byte = r_wdata[{r_issue[1:0], 3'b000} +: 8];
  end

  assign busy = (r_state != S_IDLE);

  // Request sequencing: accept, issue bytes, capture read data, pulse completion
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_len     <= 3'd0;
      r_issue   <= 3'd0;
      r_cap     <= 3'd0;
      r_rd_vld  <= 1'b0;
      r_din_vld <= 1'b0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
      mem_wr    <= 1'b0;
      lsb_valid <= 1'b0;
      lsb_rdata <= 32'd0;
    end else if (!rdy_in) begin
      // Frozen: only the write strobe drops so a byte is never written twice
      mem_wr <= 1'b0;
    end else begin
      mem_wr    <= 1'b0;
      lsb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsb_enable && !clear_in) begin
            r_addr    <= lsb_addr;
            r_wdata   <= lsb_wdata;
            r_len     <= w_req_len;
            r_cap     <= 3'd0;
            lsb_rdata <= 32'd0;
            mem_a     <= lsb_addr;
            if (lsb_wr_tag) begin
              r_state <= S_WRITE;
              if (w_req_stall) begin
                r_issue <= 3'd0;
              end else begin
                r_issue  <= 3'd1;
                mem_dout <= lsb_wdata[7:0];
                mem_wr   <= 1'b1;
              end
            end else begin
              r_state  <= S_READ;
              r_issue  <= 3'd1;
              r_rd_vld <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (clear_in) begin
            // Rollback: the load is squashed and its partial data dropped
            r_state   <= S_IDLE;
            r_issue   <= 3'd0;
            r_cap     <= 3'd0;
            r_rd_vld  <= 1'b0;
            r_din_vld <= 1'b0;
            mem_a     <= 32'd0;
            lsb_rdata <= 32'd0;
          end else begin
            r_din_vld <= r_rd_vld;
            if (r_issue != r_len) begin
              mem_a    <= w_issue_addr;
              r_issue  <= r_issue + 3'd1;
              r_rd_vld <= 1'b1;
            end else begin
              mem_a    <= 32'd0;
              r_rd_vld <= 1'b0;
            end
            if (r_din_vld) begin
              lsb_rdata[{r_cap[1:0], 3'b000} +: 8] <= mem_din;
              r_cap <= r_cap + 3'd1;
              if (r_cap == r_len - 3'd1) begin
                r_state   <= S_DONE;
                lsb_valid <= 1'b1;
                r_din_vld <= 1'b0;
              end
            end
          end
        end
        S_WRITE: begin
          // clear_in is ignored: an issued store is already committed
          if (r_issue == r_len) begin
            r_state   <= S_DONE;
            lsb_valid <= 1'b1;
            mem_a     <= 32'd0;
          end else if (!w_io_stall) begin
            mem_a    <= w_issue_addr;
            mem_dout <= w_issue_byte;
            mem_wr   <= 1'b1;
            r_issue  <= r_issue + 3'd1;
          end
        end
        default: begin
          // DONE: the completion pulse is already on lsb_valid this cycle
          r_state <= S_IDLE;
          r_issue <= 3'd0;
          r_cap   <= 3'd0;
        end
      endcase
    end
  end

endmodule
